// File: rtl/clkgen_reconfig_pkg.sv
// Shared types and constants for the DCM_CLKGEN reconfiguration sequencer.
// State encoding, serial command codes and frame helpers live here.
package clkgen_reconfig_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_D,
        S_GAP_D,
        S_LOAD_M,
        S_GAP_M,
        S_GO,
        S_WAIT_DONE
    } state_t;

    localparam logic [1:0] CMD_LOADD = 2'b10;
    localparam logic [1:0] CMD_LOADM = 2'b11;
    localparam int         FRAME_LEN = 10;

    // The DCM takes M-1 / D-1, so 256 wraps to 8'hFF and 1 to 8'h00.
    function automatic logic [7:0] frame_val(input logic [8:0] v);
        return 8'(v - 9'd1);
    endfunction

    function automatic logic in_range(input logic [8:0] v,
                                      input logic [8:0] lo);
        return (v >= lo) && (v <= 9'd256);
    endfunction

endpackage

// File: rtl/clkgen_prog_shifter.sv
// 10-bit PROGDATA serializer: two command bits first, then the value LSB first.
// Zeros are shifted in, so data_bit is 0 once the frame has gone out.
module clkgen_prog_shifter
    import clkgen_reconfig_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [1:0] cmd,
    input  logic [7:0] value,
    output logic       data_bit,
    output logic       enable,
    output logic       last
);

    logic [9:0] sr;
    logic [3:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sr     <= '0;
            cnt    <= '0;
            enable <= 1'b0;
        end else if (load) begin
            sr     <= {value, cmd[0], cmd[1]};
            cnt    <= '0;
            enable <= 1'b1;
        end else if (enable) begin
            sr  <= {1'b0, sr[9:1]};
            cnt <= cnt + 4'd1;
            if (last) begin
                enable <= 1'b0;
            end
        end
    end

    assign data_bit = sr[0];
    assign last     = enable && (cnt == 4'(FRAME_LEN - 1));

endmodule

// File: rtl/clkgen_reconfig.sv
// DCM_CLKGEN dynamic reconfiguration sequencer: LOADD, LOADM, GO, then
// waits for PROGDONE with a timeout. PROGCLK is the same net as clk_i.
module clkgen_reconfig
    import clkgen_reconfig_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000,
    parameter int          GAP_CYCLES     = 2
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [8:0] mul_i,
    input  logic [8:0] div_i,
    input  logic       load_i,
    output logic       prog_en_o,
    output logic       prog_data_o,
    input  logic       prog_done_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       error_o,
    output logic [8:0] mul_o,
    output logic [8:0] div_o
);

    state_t      state;
    logic [8:0]  mul_q;
    logic [8:0]  div_q;
    logic [7:0]  gap_cnt;
    logic [15:0] wait_cnt;

    logic        sh_load;
    logic [1:0]  sh_cmd;
    logic [7:0]  sh_value;
    logic        sh_bit;
    logic        sh_en;
    logic        sh_last;
    logic        frame_end;
    logic        gap_end;
    logic        req_ok;

    assign req_ok    = in_range(mul_i, 9'd2) && in_range(div_i, 9'd1);
    assign gap_end   = (gap_cnt == 8'(GAP_CYCLES - 1));
    assign frame_end = sh_en && sh_last;

    // Frames are launched on the same edge the FSM enters LOAD_D / LOAD_M.
    always_comb begin
        sh_load  = 1'b0;
        sh_cmd   = CMD_LOADD;
        sh_value = frame_val(div_i);
        if (state == S_IDLE && load_i && req_ok) begin
            sh_load = 1'b1;
        end else if (state == S_GAP_D && gap_end) begin
            sh_load  = 1'b1;
            sh_cmd   = CMD_LOADM;
            sh_value = frame_val(mul_q);
        end
    end

    clkgen_prog_shifter u_shifter (
        .clk      (clk_i),
        .reset    (reset_i),
        .load     (sh_load),
        .cmd      (sh_cmd),
        .value    (sh_value),
        .data_bit (sh_bit),
        .enable   (sh_en),
        .last     (sh_last)
    );

    assign prog_data_o = sh_bit;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state     <= S_IDLE;
            prog_en_o <= 1'b0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            error_o   <= 1'b0;
            mul_o     <= 9'd2;
            div_o     <= 9'd2;
            mul_q     <= 9'd2;
            div_q     <= 9'd2;
            gap_cnt   <= '0;
            wait_cnt  <= '0;
        end else begin
            done_o <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (load_i && !req_ok) begin
                        error_o <= 1'b1;
                        done_o  <= 1'b1;
                    end else if (load_i) begin
                        mul_q     <= mul_i;
                        div_q     <= div_i;
                        error_o   <= 1'b0;
                        busy_o    <= 1'b1;
                        prog_en_o <= 1'b1;
                        state     <= S_LOAD_D;
                    end
                end
                S_LOAD_D: begin
                    if (frame_end) begin
                        prog_en_o <= 1'b0;
                        gap_cnt   <= '0;
                        state     <= S_GAP_D;
                    end
                end
                S_GAP_D: begin
                    if (gap_end) begin
                        prog_en_o <= 1'b1;
                        state     <= S_LOAD_M;
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end
                S_LOAD_M: begin
                    if (frame_end) begin
                        prog_en_o <= 1'b0;
                        gap_cnt   <= '0;
                        state     <= S_GAP_M;
                    end
                end
                S_GAP_M: begin
                    if (gap_end) begin
                        prog_en_o <= 1'b1;
                        state     <= S_GO;
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end
                S_GO: begin
                    prog_en_o <= 1'b0;
                    wait_cnt  <= '0;
                    state     <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (prog_done_i) begin
                        mul_o  <= mul_q;
                        div_o  <= div_q;
                        done_o <= 1'b1;
                        busy_o <= 1'b0;
                        state  <= S_IDLE;
                    end else if (wait_cnt == TIMEOUT_CYCLES - 16'd1) begin
                        error_o <= 1'b1;
                        done_o  <= 1'b1;
                        busy_o  <= 1'b0;
                        state   <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clkgen_reconfig.sv
// Scoreboard bench for clkgen_reconfig: expected PROGEN bursts and done
// pulses are queued by the stimulus and checked by a negedge monitor.
module tb_clkgen_reconfig;

    localparam int TO = 100;

    typedef struct {
        int         len;
        logic [9:0] bits;
        int         gap;
    } run_t;

    typedef struct {
        logic       err;
        logic [8:0] mul;
        logic [8:0] div;
        int         delay;
    } done_t;

    logic       clk;
    logic       reset_i;
    logic [8:0] mul_i;
    logic [8:0] div_i;
    logic       load_i;
    logic       prog_en_o;
    logic       prog_data_o;
    logic       prog_done_i;
    logic       busy_o;
    logic       done_o;
    logic       error_o;
    logic [8:0] mul_o;
    logic [8:0] div_o;

    run_t  run_q[$];
    done_t done_q[$];
    int    compared;
    int    mismatched;

    clkgen_reconfig #(
        .TIMEOUT_CYCLES (16'(TO)),
        .GAP_CYCLES     (2)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .mul_i       (mul_i),
        .div_i       (div_i),
        .load_i      (load_i),
        .prog_en_o   (prog_en_o),
        .prog_data_o (prog_data_o),
        .prog_done_i (prog_done_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .error_o     (error_o),
        .mul_o       (mul_o),
        .div_o       (div_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: frames PROGEN bursts and checks them and done pulses.
    int         nidx = 0;
    int         wait_entry = 0;
    int         low_cnt = 0;
    bit         in_run = 0;
    int         run_len = 0;
    int         run_gap = 0;
    logic [9:0] run_bits = '0;

    always @(negedge clk) begin
        run_t  r;
        done_t d;
        nidx++;
        if (prog_en_o === 1'b1) begin
            if (!in_run) begin
                in_run   = 1;
                run_len  = 0;
                run_bits = '0;
                run_gap  = low_cnt;
            end
            run_bits = {run_bits[8:0], prog_data_o};
            run_len++;
        end else begin
            check("data_idle", 32'(prog_data_o), 32'd0);
            if (in_run) begin
                in_run     = 0;
                low_cnt    = 1;
                wait_entry = nidx;
                compared++;
                if (run_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL run_unexpected: got len %0d bits %b, expected none",
                             run_len, run_bits);
                end else begin
                    r = run_q.pop_front();
                    if (run_len != r.len || run_bits !== r.bits ||
                        (r.gap >= 0 && run_gap != r.gap)) begin
                        mismatched++;
                        $display("FAIL run: got len %0d bits %b gap %0d, expected len %0d bits %b gap %0d",
                                 run_len, run_bits, run_gap, r.len, r.bits, r.gap);
                    end
                end
            end else begin
                low_cnt++;
            end
        end
        if (done_o === 1'b1) begin
            compared++;
            if (done_q.size() == 0) begin
                mismatched++;
                $display("FAIL done_unexpected: got done at idx %0d, expected none", nidx);
            end else begin
                d = done_q.pop_front();
                if (error_o !== d.err || mul_o !== d.mul || div_o !== d.div ||
                    (d.delay >= 0 && (nidx - wait_entry) != d.delay)) begin
                    mismatched++;
                    $display("FAIL done: got err %0b mul %0d div %0d delay %0d, expected err %0b mul %0d div %0d delay %0d",
                             error_o, mul_o, div_o, nidx - wait_entry,
                             d.err, d.mul, d.div, d.delay);
                end
            end
        end
    end

    task automatic push_seq(input logic [9:0] dbits, input logic [9:0] mbits);
        run_q.push_back('{len: 10, bits: dbits, gap: -1});
        run_q.push_back('{len: 10, bits: mbits, gap: 2});
        run_q.push_back('{len: 1, bits: 10'b0, gap: 2});
    endtask

    task automatic push_done(input logic e, input logic [8:0] m,
                             input logic [8:0] dv, input int dl);
        done_q.push_back('{err: e, mul: m, div: dv, delay: dl});
    endtask

    // Returns at the negedge right after the load edge (relative cycle 0).
    task automatic do_load(input logic [8:0] m, input logic [8:0] dv);
        @(negedge clk);
        load_i = 1'b1;
        mul_i  = m;
        div_i  = dv;
        @(negedge clk);
        load_i = 1'b0;
    endtask

    task automatic pulse_done_at(input int rel_from_now);
        repeat (rel_from_now - 1) @(negedge clk);
        prog_done_i = 1'b1;
        @(negedge clk);
        prog_done_i = 1'b0;
    endtask

    initial begin
        compared    = 0;
        mismatched  = 0;
        reset_i     = 1'b1;
        load_i      = 1'b0;
        mul_i       = '0;
        div_i       = '0;
        prog_done_i = 1'b0;
        repeat (3) @(negedge clk);
        reset_i = 1'b0;
        check("rst_en", 32'(prog_en_o), 32'd0);
        check("rst_data", 32'(prog_data_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_err", 32'(error_o), 32'd0);
        check("rst_mul", 32'(mul_o), 32'd2);
        check("rst_div", 32'(div_o), 32'd2);
        repeat (2) @(negedge clk);

        // M=4, D=2 with PROGDONE at cycle 30.
        push_seq(10'b1010000000, 10'b1111000000);
        push_done(1'b0, 9'd4, 9'd2, 5);
        do_load(9'd4, 9'd2);
        check("busy_load", 32'(busy_o), 32'd1);
        pulse_done_at(30);
        repeat (3) @(negedge clk);
        check("mul_4", 32'(mul_o), 32'd4);
        check("div_2", 32'(div_o), 32'd2);
        check("busy_idle", 32'(busy_o), 32'd0);

        // Illegal requests: M=1, D=0, M=257.
        push_done(1'b1, 9'd4, 9'd2, -1);
        do_load(9'd1, 9'd2);
        check("ill_busy", 32'(busy_o), 32'd0);
        check("ill_err", 32'(error_o), 32'd1);
        repeat (3) @(negedge clk);
        push_done(1'b1, 9'd4, 9'd2, -1);
        do_load(9'd4, 9'd0);
        repeat (3) @(negedge clk);
        push_done(1'b1, 9'd4, 9'd2, -1);
        do_load(9'd257, 9'd5);
        repeat (3) @(negedge clk);
        check("ill_mul", 32'(mul_o), 32'd4);

        // M=256, D=256; stray PROGDONE in LOAD_D and a second load in LOAD_M.
        push_seq(10'b1011111111, 10'b1111111111);
        push_done(1'b0, 9'd256, 9'd256, 3);
        do_load(9'd256, 9'd256);
        check("err_clr", 32'(error_o), 32'd0);
        pulse_done_at(3);
        repeat (12) @(negedge clk);
        load_i = 1'b1;
        mul_i  = 9'd4;
        div_i  = 9'd2;
        @(negedge clk);
        load_i = 1'b0;
        pulse_done_at(12);
        repeat (10) @(negedge clk);
        check("mul_256", 32'(mul_o), 32'd256);

        // M=2, D=1 with PROGDONE never arriving.
        push_seq(10'b1000000000, 10'b1110000000);
        push_done(1'b1, 9'd256, 9'd256, TO);
        do_load(9'd2, 9'd1);
        repeat (25 + TO + 4) @(negedge clk);
        check("to_mul", 32'(mul_o), 32'd256);
        check("to_div", 32'(div_o), 32'd256);

        // Reset during LOAD_M after three M-frame bits.
        run_q.push_back('{len: 10, bits: 10'b1010000000, gap: -1});
        run_q.push_back('{len: 3, bits: 10'b0000000111, gap: 2});
        do_load(9'd4, 9'd2);
        repeat (14) @(negedge clk);
        reset_i = 1'b1;
        @(negedge clk);
        check("mid_en", 32'(prog_en_o), 32'd0);
        check("mid_busy", 32'(busy_o), 32'd0);
        check("mid_mul", 32'(mul_o), 32'd2);
        check("mid_err", 32'(error_o), 32'd0);
        reset_i = 1'b0;
        repeat (5) @(negedge clk);

        // Normal load after the abort: M=10, D=3.
        push_seq(10'b1001000000, 10'b1110010000);
        push_done(1'b0, 9'd10, 9'd3, 5);
        do_load(9'd10, 9'd3);
        pulse_done_at(30);
        repeat (5) @(negedge clk);
        check("fin_mul", 32'(mul_o), 32'd10);
        check("fin_div", 32'(div_o), 32'd3);

        check("runs_left", 32'(run_q.size()), 32'd0);
        check("dones_left", 32'(done_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
